// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch stage.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W   = 8;
    localparam int unsigned CPU_INSTR_W  = 16;
    localparam int unsigned CPU_RESET_PC = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO holding fetched {pc, instruction} entries; flush empties it in one cycle.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    // Pointer and count update; flush overrides any same-cycle push or pop.
    always_comb begin
        push_en  = push & ~flush;
        pop_en   = pop & (count_q != '0) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_en) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/cpu_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency reads, buffers returned words,
// and hands them to the controller over valid/ready. Redirect flushes and restarts.
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = CPU_ADDR_W,
    parameter int unsigned       INSTR_W  = CPU_INSTR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   enable,
    output logic                   imem_en,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]     imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_W-1:0]     instr,
    output logic [ADDR_W-1:0]      instr_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned OCC_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              drop_q, drop_d;

    logic [OCC_W-1:0]   credit;
    logic               issue;
    logic               push;
    logic               pop;
    logic               flush;
    logic [ENTRY_W-1:0] q_head;
    logic [OCC_W-1:0]   q_count;
    logic               q_empty;
    logic               q_full;

    // Issue decision from credits, plus next-state for PC, FSM and in-flight tracking.
    always_comb begin
        credit     = q_count + OCC_W'(inflight_q);
        issue      = (state_q == RUN) & enable & ~redirect & (credit < OCC_W'(DEPTH));
        flush      = redirect & (state_q == RUN);
        push       = inflight_q & ~drop_q;
        pop        = ~q_empty & instr_ready;

        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        // A read whose data is on the bus during a flush is disowned; since no
        // request is issued in a redirect cycle, nothing stale can land afterwards.
        drop_d     = flush & inflight_q;

        if (state_q == IDLE && start) state_d = RUN;

        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d     = pc_q + ADDR_W'(1);
            req_pc_d = pc_q;
        end
    end

    // FSM, PC and in-flight registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Credit accounting must keep a landing response from overrunning the queue.
    always_ff @(posedge clock) begin
        if (reset && push && !flush) begin
            assert (!q_full || pop);
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({req_pc_q, imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign imem_en     = issue;
    assign imem_addr   = pc_q;
    assign instr_valid = ~q_empty;
    assign instr       = q_head[INSTR_W-1:0];
    assign instr_pc    = q_head[ENTRY_W-1:INSTR_W];
    assign occupancy   = q_count;

endmodule
